// File: rtl/icache_valid_ctrl.sv
// icache_valid_ctrl
//   Valid-bit store for an instruction cache: a NUM_SETS x NUM_WAYS array of
//   valid flops with single-cycle lookup, per-way fill, per-set invalidate and
//   a sequenced full-cache flush that sweeps one set per cycle.
//
// Ports
//   clk_i, rst_i         clock (rising edge), async active-high reset
//   lookup_req_i/idx_i   lookup request and set index
//   lookup_valid_o       one-cycle strobe, one cycle after an accepted lookup
//   lookup_ways_o        valid bits of the looked-up set (held between strobes)
//   fill_i/idx_i/way_i   set one valid bit
//   inv_i/inv_idx_i      clear every way of one set
//   flush_req_i          start a full flush sweep
//   ready_o              lookup/fill/inv are accepted this cycle
//   flush_busy_o         sweep (or its done cycle) in progress
//   flush_done_o         one-cycle pulse at the end of a sweep
//
// state | meaning
// IDLE  | normal operation, requests accepted
// FLUSH | clearing set[cnt_q], one set per cycle
// DONE  | sweep finished, flush_done_o pulses, back to IDLE next cycle
module icache_valid_ctrl #(
    parameter int NUM_WAYS = 2,
    parameter int IDX_W    = 8,
    localparam int NUM_SETS = 2 ** IDX_W,
    localparam int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                lookup_req_i,
    input  logic [IDX_W-1:0]    lookup_idx_i,
    output logic                lookup_valid_o,
    output logic [NUM_WAYS-1:0] lookup_ways_o,
    input  logic                fill_i,
    input  logic [IDX_W-1:0]    fill_idx_i,
    input  logic [WAY_W-1:0]    fill_way_i,
    input  logic                inv_i,
    input  logic [IDX_W-1:0]    inv_idx_i,
    input  logic                flush_req_i,
    output logic                ready_o,
    output logic                flush_busy_o,
    output logic                flush_done_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    cnt_q, cnt_d;
    logic                sweep_clr;
    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0] fill_mask;
    logic                lookup_acc, fill_acc, inv_acc;

    // A pending flush request already blocks new traffic in the cycle it is
    // raised, so nothing slips in between the request and the sweep start.
    assign ready_o      = (state_q == ST_IDLE) && !flush_req_i;
    assign flush_busy_o = (state_q != ST_IDLE);
    assign flush_done_o = (state_q == ST_DONE);

    assign lookup_acc = lookup_req_i && ready_o;
    assign fill_acc   = fill_i && ready_o;
    assign inv_acc    = inv_i && ready_o;

    // Out-of-range ways decode to an empty mask, so such fills are dropped.
    always_comb begin
        fill_mask = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (fill_way_i == WAY_W'(w)) begin
                fill_mask[w] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sweep_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (flush_req_i) begin
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                end
            end
            ST_FLUSH: begin
                sweep_clr = 1'b1;
                if (cnt_q == '1) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Clear (sweep or inv) has priority over fill on the same set.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < NUM_SETS; s++) begin
                if ((sweep_clr && (cnt_q == IDX_W'(s))) ||
                    (inv_acc && (inv_idx_i == IDX_W'(s)))) begin
                    valid_q[s] <= '0;
                end else if (fill_acc && (fill_idx_i == IDX_W'(s))) begin
                    valid_q[s] <= valid_q[s] | fill_mask;
                end
            end
        end
    end

    // Reads the pre-edge array contents, so same-cycle fill/inv are not seen.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lookup_valid_o <= 1'b0;
            lookup_ways_o  <= '0;
        end else begin
            lookup_valid_o <= lookup_acc;
            if (lookup_acc) begin
                lookup_ways_o <= valid_q[lookup_idx_i];
            end
        end
    end

endmodule

// File: tb/tb_icache_valid_ctrl.sv
module tb_icache_valid_ctrl;

    localparam int IDX_W    = 3;
    localparam int NUM_WAYS = 2;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       lookup_req_i = 1'b0;
    logic [2:0] lookup_idx_i = '0;
    logic       lookup_valid_o;
    logic [1:0] lookup_ways_o;
    logic       fill_i = 1'b0;
    logic [2:0] fill_idx_i = '0;
    logic       fill_way_i = 1'b0;
    logic       inv_i = 1'b0;
    logic [2:0] inv_idx_i = '0;
    logic       flush_req_i = 1'b0;
    logic       ready_o;
    logic       flush_busy_o;
    logic       flush_done_o;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [1:0] exp_q[$];

    icache_valid_ctrl #(.NUM_WAYS(NUM_WAYS), .IDX_W(IDX_W)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .lookup_req_i   (lookup_req_i),
        .lookup_idx_i   (lookup_idx_i),
        .lookup_valid_o (lookup_valid_o),
        .lookup_ways_o  (lookup_ways_o),
        .fill_i         (fill_i),
        .fill_idx_i     (fill_idx_i),
        .fill_way_i     (fill_way_i),
        .inv_i          (inv_i),
        .inv_idx_i      (inv_idx_i),
        .flush_req_i    (flush_req_i),
        .ready_o        (ready_o),
        .flush_busy_o   (flush_busy_o),
        .flush_done_o   (flush_done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: every response must match the oldest outstanding expectation.
    always @(negedge clk_i) begin
        if (lookup_valid_o) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_lookup: got response ways=%b with no lookup outstanding", lookup_ways_o);
            end else begin
                chk("lookup_ways", int'(lookup_ways_o), int'(exp_q.pop_front()));
            end
        end
    end

    // One cycle of stimulus; a lookup pushes its hand-computed expectation.
    task automatic step(input logic lk, input logic [2:0] li,
                        input logic fl, input logic [2:0] fi, input logic fw,
                        input logic iv, input logic [2:0] ii,
                        input logic [1:0] exp);
        lookup_req_i = lk; lookup_idx_i = li;
        fill_i = fl; fill_idx_i = fi; fill_way_i = fw;
        inv_i = iv; inv_idx_i = ii;
        if (lk) exp_q.push_back(exp);
        @(posedge clk_i); #1;
        lookup_req_i = 1'b0; fill_i = 1'b0; inv_i = 1'b0;
    endtask

    task automatic lookup(input logic [2:0] idx, input logic [1:0] exp);
        step(1'b1, idx, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, exp);
    endtask

    task automatic fill(input logic [2:0] idx, input logic way);
        step(1'b0, 3'd0, 1'b1, idx, way, 1'b0, 3'd0, 2'b00);
    endtask

    // Observes a sweep already in FLUSH; drops flush_req_i at cycle drop_at
    // and any held lookup/fill on the done cycle.
    task automatic watch_sweep(input int drop_at, output int nb, output int nd,
                               output int done_at, output int rdy_bad);
        nb = 0; nd = 0; done_at = 0; rdy_bad = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk_i);
            if (i == drop_at) flush_req_i = 1'b0;
            if (flush_busy_o) begin
                nb++;
                if (ready_o) rdy_bad++;
            end
            if (flush_done_o) begin
                nd++;
                done_at = i;
                lookup_req_i = 1'b0;
                fill_i = 1'b0;
            end
            if (!flush_busy_o) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, nd, done_at, rdy_bad;

        #3;
        chk("rst_lookup_valid", int'(lookup_valid_o), 0);
        chk("rst_lookup_ways", int'(lookup_ways_o), 0);
        chk("rst_busy", int'(flush_busy_o), 0);
        chk("rst_done", int'(flush_done_o), 0);
        chk("rst_ready", int'(ready_o), 1);
        #19 rst_i = 1'b0;

        // fill then lookup
        fill(3'd5, 1'b1);
        lookup(3'd5, 2'b10);
        @(negedge clk_i); @(negedge clk_i);
        chk("ways_hold_valid", int'(lookup_valid_o), 0);
        chk("ways_hold_value", int'(lookup_ways_o), 2);

        // read-before-write against fill and inv
        step(1'b1, 3'd2, 1'b1, 3'd2, 1'b0, 1'b0, 3'd0, 2'b00);
        lookup(3'd2, 2'b01);
        step(1'b1, 3'd2, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 2'b01);
        lookup(3'd2, 2'b00);

        // inv wins on the same set; different sets both apply
        step(1'b0, 3'd0, 1'b1, 3'd3, 1'b0, 1'b1, 3'd3, 2'b00);
        lookup(3'd3, 2'b00);
        fill(3'd6, 1'b1);
        step(1'b0, 3'd0, 1'b1, 3'd5, 1'b0, 1'b1, 3'd6, 2'b00);
        lookup(3'd5, 2'b11);
        lookup(3'd6, 2'b00);

        // inv held between edges has no effect until the edge
        fill(3'd1, 1'b1);
        inv_i = 1'b1; inv_idx_i = 3'd1;
        #3;
        step(1'b1, 3'd1, 1'b0, 3'd0, 1'b0, 1'b1, 3'd1, 2'b10);
        lookup(3'd1, 2'b00);

        // full flush of a full cache, traffic held during the sweep
        for (int s = 0; s < 8; s++) begin
            fill(3'(s), 1'b0);
            fill(3'(s), 1'b1);
        end
        lookup(3'd0, 2'b11);
        lookup(3'd7, 2'b11);
        flush_req_i = 1'b1; lookup_req_i = 1'b1; lookup_idx_i = 3'd4;
        fill_i = 1'b1; fill_idx_i = 3'd0; fill_way_i = 1'b0;
        #1 chk("ready_on_flush_req", int'(ready_o), 0);
        @(posedge clk_i); #1;
        flush_req_i = 1'b0;
        watch_sweep(0, nb, nd, done_at, rdy_bad);
        chk("flush_busy_cycles", nb, 9);
        chk("flush_done_count", nd, 1);
        chk("flush_done_cycle", done_at, 9);
        chk("flush_ready_low", rdy_bad, 0);
        for (int s = 0; s < 8; s++) lookup(3'(s), 2'b00);

        // flush_req held during the sweep does not restart it
        flush_req_i = 1'b1;
        @(posedge clk_i); #1;
        watch_sweep(5, nb, nd, done_at, rdy_bad);
        flush_req_i = 1'b0;
        chk("reflush_busy_cycles", nb, 9);
        chk("reflush_done_count", nd, 1);
        chk("reflush_done_cycle", done_at, 9);

        // reset mid-sweep
        fill(3'd6, 1'b0);
        lookup(3'd6, 2'b01);
        flush_req_i = 1'b1;
        @(posedge clk_i); #1;
        flush_req_i = 1'b0;
        repeat (4) @(negedge clk_i);
        chk("pre_rst_busy", int'(flush_busy_o), 1);
        rst_i = 1'b1;
        #1;
        chk("mid_rst_busy", int'(flush_busy_o), 0);
        chk("mid_rst_done", int'(flush_done_o), 0);
        chk("mid_rst_lookup_valid", int'(lookup_valid_o), 0);
        chk("mid_rst_lookup_ways", int'(lookup_ways_o), 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        nb = 0; nd = 0; rdy_bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_i);
            if (flush_busy_o) nb++;
            if (flush_done_o) nd++;
            if (!ready_o) rdy_bad++;
        end
        chk("post_rst_busy", nb, 0);
        chk("post_rst_done", nd, 0);
        chk("post_rst_ready_low", rdy_bad, 0);
        lookup(3'd6, 2'b00);

        repeat (3) @(negedge clk_i);
        chk("all_responses_seen", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/icache_valid_ctrl.md
ICACHE_VALID_CTRL -- requirements
Module: icache_valid_ctrl

Interface
REQ-001 SHALL have parameter NUM_WAYS, default 2: ways per set (power of two, >=1).
REQ-002 SHALL have parameter IDX_W, default 8: set index width; NUM_SETS = 2**IDX_W.
REQ-003 SHALL derive WAY_W = max(1, clog2(NUM_WAYS)).
REQ-004 SHALL have port clk_i  in  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port lookup_req_i  in  1  lookup request.
REQ-007 SHALL have port lookup_idx_i  in  IDX_W  lookup set index.
REQ-008 SHALL have port lookup_valid_o  out  1  lookup result valid.
REQ-009 SHALL have port lookup_ways_o  out  NUM_WAYS  valid bits of the looked-up set.
REQ-010 SHALL have port fill_i  in  1  mark a line valid.
REQ-011 SHALL have port fill_idx_i  in  IDX_W  fill set; fill_way_i  in  WAY_W  fill way.
REQ-012 SHALL have port inv_i  in  1  invalidate all ways of a set; inv_idx_i  in  IDX_W  set.
REQ-013 SHALL have port flush_req_i  in  1  request a full-cache flush.
REQ-014 SHALL have port ready_o  out  1  high when lookup, fill and inv are accepted.
REQ-015 SHALL have port flush_busy_o  out  1  flush sweep in progress.
REQ-016 SHALL have port flush_done_o  out  1  one-cycle pulse at the end of a flush.

Function
REQ-017 SHALL hold a valid array of NUM_SETS x NUM_WAYS flops.
REQ-018 SHALL implement FSM states IDLE, FLUSH and DONE.
REQ-019 IDLE: flush_req_i=1 SHALL move the FSM to FLUSH, with sweep counter=0.
REQ-020 FLUSH: each cycle SHALL clear all ways of set[counter] and increment the counter; at counter=NUM_SETS-1 the FSM SHALL clear that set and move to DONE (NUM_SETS cycles in FLUSH).
REQ-021 DONE: SHALL assert flush_done_o for exactly that cycle, then return to IDLE.
REQ-022 flush_busy_o SHALL equal 1 in FLUSH and DONE, and 0 otherwise.
REQ-023 ready_o SHALL equal (state==IDLE) && !flush_req_i.
REQ-024 With ready_o=0, lookup_req_i, fill_i and inv_i SHALL be ignored (no state change, no lookup response).
REQ-025 flush_req_i in FLUSH or DONE SHALL be ignored; no restart and no queuing.
REQ-026 An accepted lookup SHALL assert lookup_valid_o exactly one cycle later, with lookup_ways_o = the set's valid bits before any same-cycle fill or inv (read-before-write).
REQ-027 lookup_valid_o SHALL be 0 in every cycle not covered by REQ-026, including the cycle after flush_req_i is taken.
REQ-028 lookup_ways_o SHALL hold its last value while lookup_valid_o=0.
REQ-029 An accepted fill SHALL set valid[fill_idx_i][fill_way_i] on the next edge; fill_way_i >= NUM_WAYS SHALL be ignored.
REQ-030 An accepted inv SHALL clear all ways of set inv_idx_i on the next edge.
REQ-031 When fill and inv target the same set in the same cycle, inv SHALL win and the set SHALL end all-zero.
REQ-032 Fill and inv to different sets in the same cycle SHALL both take effect.
REQ-033 Flush SHALL be a synchronous sequenced operation only; flush_req_i and inv_i SHALL never feed any asynchronous reset or clear path.

Reset
REQ-034 rst_i=1 SHALL asynchronously clear the valid array, set state=IDLE and counter=0, and drive lookup_valid_o=0, lookup_ways_o=0, flush_busy_o=0 and flush_done_o=0.
REQ-035 rst_i asserted mid-flush SHALL abort the sweep; after release the FSM SHALL be in IDLE with no flush_done_o pulse.
REQ-036 Reset SHALL be the only asynchronous path; no other input SHALL alter state except on a clk_i edge.

Verification (IDX_W=3, NUM_WAYS=2)
REQ-037 Fill idx 5 way 1, then lookup idx 5 -> lookup_valid_o=1 one cycle later with lookup_ways_o=2'b10.
REQ-038 Fill idx 2 way 0 and lookup idx 2 in the same cycle -> lookup_ways_o=2'b00; a second lookup -> 2'b01.
REQ-039 Fill idx 3 way 0 and inv idx 3 in the same cycle -> a lookup of idx 3 returns 2'b00.
REQ-040 All sets filled, flush_req_i pulsed -> flush_busy_o high for 9 cycles, flush_done_o pulses on cycle 9, ready_o=0 throughout, every set then reads 2'b00, and lookups issued during the sweep get no response.
REQ-041 rst_i asserted at sweep cycle 4 -> all outputs 0 immediately; after release ready_o=1 and no flush_done_o pulse occurs.
REQ-042 inv_i held high with rst_i low and no clk_i edge -> no state change; flush_req_i during FLUSH -> sweep length stays 8 cycles with a single done pulse.
